// File: rtl/oqpsk_channel_sequencer.sv
// Per-channel bit/sample sequencer for the OQPSK transmit path.
// Channel k lags channel 0 by k*OFFSET_SAMPLES sample ticks.
module oqpsk_channel_sequencer #(
  parameter int NUM_CHANNELS = 2,
  parameter int SAMPLES_PER_SYMBOL = 4,
  parameter int C_S00_AXIS_TDATA_WIDTH = 16,
  parameter int OFFSET_SAMPLES = 2,
  localparam int BITS = C_S00_AXIS_TDATA_WIDTH / NUM_CHANNELS,
  localparam int CW = $clog2(BITS),
  localparam int SW = $clog2(SAMPLES_PER_SYMBOL)
) (
  input  logic                       aclk,
  input  logic                       sreset,
  input  logic                       start_fsms,
  input  logic                       sample_en,
  input  logic [NUM_CHANNELS-1:0]    last_packet,
  output logic [NUM_CHANNELS*CW-1:0] data_counter_out,
  output logic [NUM_CHANNELS*SW-1:0] sample_counter_out,
  output logic [NUM_CHANNELS*2-1:0]  channel_state_out,
  output logic [NUM_CHANNELS-1:0]    receive_data,
  output logic                       end_of_transmission
);

  localparam int MAX_LAG = (NUM_CHANNELS - 1) * OFFSET_SAMPLES;
  localparam int OW = (MAX_LAG > 1) ? $clog2(MAX_LAG) : 1;
  localparam int SPS = SAMPLES_PER_SYMBOL;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OFFSET   = 2'd1,
    TRANSMIT = 2'd2,
    DONE     = 2'd3
  } state_t;

  logic [NUM_CHANNELS-1:0] idle_vec;
  logic [NUM_CHANNELS-1:0] done_vec;
  logic                    all_idle;
  logic                    all_done;
  logic                    start_go;

  assign all_idle = &idle_vec;
  assign all_done = &done_vec;
  assign start_go = start_fsms && all_idle;

  always_comb begin
    end_of_transmission = all_done;
  end

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    localparam int LAG = k * OFFSET_SAMPLES;
    localparam int LAG_END = (LAG > 0) ? LAG - 1 : 0;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   dcnt;
    logic [SW-1:0]   scnt;
    logic [OW-1:0]   ocnt;
    logic            last_sample;
    logic            finish;
    logic            lag_hit;
    logic            req;

    assign last_sample = (state == TRANSMIT) && sample_en
                      && (dcnt == CW'(BITS - 1))
                      && (scnt == SW'(SPS - 1));
    assign finish  = last_sample && last_packet[k];
    assign lag_hit = sample_en && (ocnt == OW'(LAG_END));

    always_ff @(posedge aclk) begin
      if (sreset) state <= IDLE;
      else        state <= next_state;
    end

    always_comb begin
      next_state = state;
      unique case (state)
        IDLE: begin
          if (start_go)
            next_state = (LAG == 0) ? TRANSMIT : OFFSET;
        end
        OFFSET: begin
          if (lag_hit) next_state = TRANSMIT;
        end
        TRANSMIT: begin
          if (finish) next_state = DONE;
        end
        DONE: begin
          if (all_done) next_state = IDLE;
        end
      endcase
    end

    always_comb begin
      req = last_sample && !last_packet[k];
    end

    // Counters hold through DONE and are zeroed on the way back to IDLE.
    always_ff @(posedge aclk) begin
      if (sreset) begin
        dcnt <= '0;
        scnt <= '0;
        ocnt <= '0;
      end else if (start_go || (state == DONE && all_done)) begin
        dcnt <= '0;
        scnt <= '0;
        ocnt <= '0;
      end else if (sample_en) begin
        if (state == OFFSET) begin
          ocnt <= lag_hit ? '0 : ocnt + 1'b1;
        end else if (state == TRANSMIT && !finish) begin
          if (scnt == SW'(SPS - 1)) begin
            scnt <= '0;
            dcnt <= (dcnt == CW'(BITS - 1)) ? '0 : dcnt + 1'b1;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
      end
    end

    assign idle_vec[k] = (state == IDLE);
    assign done_vec[k] = (state == DONE);
    assign receive_data[k] = req;
    assign channel_state_out[2*k +: 2] = state;
    assign data_counter_out[k*CW +: CW] = dcnt;
    assign sample_counter_out[k*SW +: SW] = scnt;
  end

endmodule

// File: tb/tb_oqpsk_channel_sequencer.sv
// Bench for oqpsk_channel_sequencer: tick-count model plus
// directed scenarios with hand-computed cycle numbers.
module tb_oqpsk_channel_sequencer;

  localparam int NC = 2;
  localparam int SPS = 4;
  localparam int BITS = 8;
  localparam int OFF = 2;
  localparam int PKT = BITS * SPS;

  logic clk = 1'b0;
  logic sreset = 1'b1;
  logic start_fsms = 1'b0;
  logic sample_en = 1'b0;
  logic [1:0] last_packet = 2'b00;

  logic [5:0] data_counter_out;
  logic [3:0] sample_counter_out;
  logic [3:0] channel_state_out;
  logic [1:0] receive_data;
  logic       end_of_transmission;

  logic [7:0] q_data;
  logic [7:0] q_sample;
  logic [7:0] q_state;
  logic [3:0] q_rd;
  logic       q_eot;

  always #5 clk = ~clk;

  oqpsk_channel_sequencer dut (
    .aclk(clk),
    .sreset(sreset),
    .start_fsms(start_fsms),
    .sample_en(sample_en),
    .last_packet(last_packet),
    .data_counter_out(data_counter_out),
    .sample_counter_out(sample_counter_out),
    .channel_state_out(channel_state_out),
    .receive_data(receive_data),
    .end_of_transmission(end_of_transmission)
  );

  oqpsk_channel_sequencer #(
    .NUM_CHANNELS(4),
    .SAMPLES_PER_SYMBOL(4),
    .C_S00_AXIS_TDATA_WIDTH(16),
    .OFFSET_SAMPLES(0)
  ) dut_q (
    .aclk(clk),
    .sreset(sreset),
    .start_fsms(start_fsms),
    .sample_en(sample_en),
    .last_packet(4'b0000),
    .data_counter_out(q_data),
    .sample_counter_out(q_sample),
    .channel_state_out(q_state),
    .receive_data(q_rd),
    .end_of_transmission(q_eot)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Model: per channel a mode, remaining lag ticks and ticks into packet.
  int m_state [NC];
  int m_lag [NC];
  int m_t [NC];

  always @(posedge clk) begin
    bit a_idle;
    bit a_done;
    a_idle = 1'b1;
    a_done = 1'b1;
    for (int k = 0; k < NC; k++) begin
      if (m_state[k] != 0) a_idle = 1'b0;
      if (m_state[k] != 3) a_done = 1'b0;
    end
    for (int k = 0; k < NC; k++) begin
      if (sreset) begin
        m_state[k] = 0; m_t[k] = 0; m_lag[k] = 0;
      end else begin
        case (m_state[k])
          0: if (start_fsms && a_idle) begin
            m_t[k] = 0;
            m_lag[k] = k * OFF;
            m_state[k] = (m_lag[k] == 0) ? 2 : 1;
          end
          1: if (sample_en) begin
            m_lag[k]--;
            if (m_lag[k] == 0) m_state[k] = 2;
          end
          2: if (sample_en) begin
            if (m_t[k] == PKT - 1) begin
              if (last_packet[k]) m_state[k] = 3;
              else m_t[k] = 0;
            end else begin
              m_t[k]++;
            end
          end
          default: if (a_done) begin
            m_state[k] = 0; m_t[k] = 0;
          end
        endcase
      end
    end
  end

  int first_rd [NC];
  int first_done [NC];
  int rd_cnt [NC];
  int eot_cyc;
  int eot_cnt;
  int q_first_rd;
  logic [3:0] q_first_val;

  task automatic clear_log();
    for (int k = 0; k < NC; k++) begin
      first_rd[k] = -1; first_done[k] = -1; rd_cnt[k] = 0;
    end
    eot_cyc = -1; eot_cnt = 0; q_first_rd = -1; q_first_val = '0;
  endtask

  always @(negedge clk) begin
    logic [3:0] e_st;
    logic [5:0] e_d;
    logic [3:0] e_s;
    logic [1:0] e_rd;
    logic e_eot;
    if (mon_on) begin
      e_eot = 1'b1;
      for (int k = 0; k < NC; k++) begin
        e_st[2*k +: 2] = 2'(m_state[k]);
        e_d[3*k +: 3] = 3'(m_t[k] / SPS);
        e_s[2*k +: 2] = 2'(m_t[k] % SPS);
        e_rd[k] = (m_state[k] == 2) && sample_en
               && (m_t[k] == PKT - 1) && !last_packet[k];
        if (m_state[k] != 3) e_eot = 1'b0;
      end
      chk("state", 64'(channel_state_out), 64'(e_st));
      chk("data_cnt", 64'(data_counter_out), 64'(e_d));
      chk("sample_cnt", 64'(sample_counter_out), 64'(e_s));
      chk("receive_data", 64'(receive_data), 64'(e_rd));
      chk("eot", 64'(end_of_transmission), 64'(e_eot));
      for (int k = 0; k < NC; k++) begin
        if (receive_data[k]) begin
          rd_cnt[k]++;
          if (first_rd[k] < 0) first_rd[k] = cyc;
        end
        if (channel_state_out[2*k +: 2] == 2'd3 && first_done[k] < 0)
          first_done[k] = cyc;
      end
      if (end_of_transmission) begin
        eot_cnt++;
        if (eot_cyc < 0) eot_cyc = cyc;
      end
      if (q_rd != 0 && q_first_rd < 0) begin
        q_first_rd = cyc; q_first_val = q_rd;
      end
    end
  end

  task automatic do_reset();
    sreset = 1'b1; start_fsms = 1'b0; sample_en = 1'b0;
    last_packet = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    sreset = 1'b0;
  endtask

  // Cycle 0 is the cycle in which start_fsms is first high.
  task automatic scen(input int mode, input int len);
    clear_log();
    for (int c = 0; c < len; c++) begin
      cyc = c;
      start_fsms = (c == 0) || (mode == 4 && (c == 50 || c == 99));
      sample_en = (mode == 3) ? (c % 2 == 1) : 1'b1;
      case (mode)
        2: last_packet = 2'b11;
        4: last_packet = {c >= 67, c >= 33};
        default: last_packet = 2'b00;
      endcase
      #1;
      if (mode == 1 && c == 1) begin
        chk("s1_state_c1", 64'(channel_state_out), 64'h6);
        chk("q_state_c1", 64'(q_state), 64'hAA);
      end
      if (mode == 1 && c == 3)
        chk("s1_state_c3", 64'(channel_state_out), 64'hA);
      if (mode == 2 && c == 36)
        chk("s2_idle_c36", 64'(channel_state_out), 64'h0);
      if (mode == 4 && c == 51)
        chk("q_ignore_start", 64'(q_state), 64'hAA);
      if (mode == 4 && (c == 100 || c == 101))
        chk("s4_idle", 64'(channel_state_out), 64'h0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    clear_log();
    do_reset();
    mon_on = 1'b1;

    scen(1, 41);
    chk("s1_first_rd0", 64'(first_rd[0]), 64'd32);
    chk("s1_first_rd1", 64'(first_rd[1]), 64'd34);
    chk("q_first_rd", 64'(q_first_rd), 64'd16);
    chk("q_first_val", 64'(q_first_val), 64'hF);
    sreset = 1'b1;
    @(posedge clk);
    #1;
    sreset = 1'b0;
    chk("rst_state", 64'(channel_state_out), 64'h0);
    chk("rst_cnt", 64'({data_counter_out, sample_counter_out}), 64'h0);
    chk("rst_q", 64'({q_state, q_data, q_sample}), 64'h0);
    chk("rst_pulses", 64'({receive_data, end_of_transmission}), 64'h0);

    do_reset();
    scen(2, 38);
    chk("s2_done0", 64'(first_done[0]), 64'd33);
    chk("s2_done1", 64'(first_done[1]), 64'd35);
    chk("s2_eot_cyc", 64'(eot_cyc), 64'd35);
    chk("s2_eot_cnt", 64'(eot_cnt), 64'd1);
    chk("s2_no_rd", 64'(rd_cnt[0] + rd_cnt[1]), 64'd0);

    do_reset();
    scen(3, 66);
    chk("s3_first_rd0", 64'(first_rd[0]), 64'd63);

    do_reset();
    scen(4, 103);
    chk("s4_done0", 64'(first_done[0]), 64'd65);
    chk("s4_rd0", 64'(rd_cnt[0]), 64'd1);
    chk("s4_rd1", 64'(rd_cnt[1]), 64'd2);
    chk("s4_eot_cyc", 64'(eot_cyc), 64'd99);
    chk("s4_eot_cnt", 64'(eot_cnt), 64'd1);

    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
